mc_ram_array: RTL and testbench

//  Parametrised successor to the 10147-class ECL bit RAM: WIDTH x DEPTH array with N_EN active-low enables.

---
 rtl/mc_ram_array.sv | 139 +++++++++++++
 tb/tb_mc_ram_array.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mc_ram_array.sv
// WIDTH x DEPTH RAM array with active-low chip enables, optional odd parity per word and a post-reset clear sequencer.
// Read data is registered: q/q_valid/perr reflect a read one clk after it is issued; writes are visible on the next cycle.
// No stall on normal accesses; while busy=1 (DEPTH cycles after reset) every access is ignored and must be reissued later.
module mc_ram_array #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH),
  parameter int N_EN   = 2,
  parameter bit PARITY = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] d,
  input  logic [N_EN-1:0]  nen,
  input  logic             nwrite,
  input  logic             perr_clr,
  input  logic             par_inj,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             perr,
  output logic             busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     clr_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              clr_phase;
  logic              cs;
  logic              we;
  logic              re;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [WIDTH-1:0]  mem_wr_dat;

  // Decode the access and pick the write source: sequencer during clear, user port in run.
  always_comb begin
    clr_phase   = (state == ST_CLEAR);
    cs          = &(~nen);
    we          = (state == ST_RUN) && cs && !nwrite;
    re          = (state == ST_RUN) && cs && nwrite;
    mem_wr_en   = !reset && (clr_phase || we);
    mem_wr_addr = clr_phase ? clr_ptr : addr;
    mem_wr_dat  = clr_phase ? '0 : d;
  end

  // Data array write port; contents are not reset, the clear sequencer initialises them.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_dat;
    end
  end

  // Control FSM with registered read port and busy flag; reset always restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          q       <= '0;
          q_valid <= 1'b0;
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(DEPTH - 1)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy <= 1'b0;
          if (re) begin
            q       <= mem[addr];
            q_valid <= 1'b1;
          end else begin
            q       <= '0;
            q_valid <= 1'b0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
          q       <= '0;
          q_valid <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (PARITY) begin : g_par
      logic par_mem [DEPTH];
      logic par_wr_dat;
      logic par_fail;
      logic perr_r;

      // Cleared words carry parity 1 (odd parity of zero); par_inj flips the stored bit to force an error.
      always_comb begin
        par_wr_dat = clr_phase ? 1'b1 : (^d ^ 1'b1 ^ par_inj);
        par_fail   = re && ((^mem[addr] ^ par_mem[addr]) != 1'b1);
      end

      // Parity bit array shares the data array's write enable and address.
      always_ff @(posedge clk) begin
        if (mem_wr_en) begin
          par_mem[mem_wr_addr] <= par_wr_dat;
        end
      end

      // Sticky error flag: a failing read beats a simultaneous clear request.
      always_ff @(posedge clk) begin
        if (reset) begin
          perr_r <= 1'b0;
        end else if (par_fail) begin
          perr_r <= 1'b1;
        end else if (perr_clr) begin
          perr_r <= 1'b0;
        end
      end

      assign perr = perr_r;
    end else begin : g_nopar
      logic unused_par_inputs;
      assign unused_par_inputs = ^{perr_clr, par_inj};
      assign perr = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mc_ram_array.sv
// Directed and random checks of mc_ram_array against a word-level model (contents, corrupted-word flags, sticky error).
// Outputs are compared 1 time unit after each rising edge.
// Clear sequencing is checked by counting busy cycles after reset release.
module tb_mc_ram_array;

  logic       clk;
  logic       reset;
  logic [3:0] addr;
  logic [3:0] d;
  logic [1:0] nen;
  logic       nwrite;
  logic       perr_clr;
  logic       par_inj;
  logic [3:0] q;
  logic       q_valid;
  logic       perr;
  logic       busy;

  int n_assert;
  int n_fail;

  // Reference model: word contents, whether a word was written with corrupted parity, sticky error.
  logic [3:0] m_mem [16];
  bit         m_bad [16];
  bit         m_perr;

  mc_ram_array #(
    .WIDTH (4),
    .DEPTH (16),
    .N_EN  (2),
    .PARITY(1'b1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .d       (d),
    .nen     (nen),
    .nwrite  (nwrite),
    .perr_clr(perr_clr),
    .par_inj (par_inj),
    .q       (q),
    .q_valid (q_valid),
    .perr    (perr),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access cycle: drive inputs, predict the result, clock, compare.
  task automatic step(input logic [1:0] en, input logic nw, input logic [3:0] a,
                      input logic [3:0] dd, input logic pc, input logic pi, input string tag);
    logic [3:0] eq;
    logic       ev;
    bit         fail;
    nen = en; nwrite = nw; addr = a; d = dd; perr_clr = pc; par_inj = pi;
    fail = 1'b0;
    eq   = 4'h0;
    ev   = 1'b0;
    if (en == 2'b00) begin
      if (!nw) begin
        m_mem[a] = dd;
        m_bad[a] = pi;
      end else begin
        eq = m_mem[a];
        ev = 1'b1;
        fail = m_bad[a];
      end
    end
    if (fail) m_perr = 1'b1;
    else if (pc) m_perr = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".q"}, q, eq);
    chk({tag, ".q_valid"}, q_valid, ev);
    chk({tag, ".perr"}, perr, m_perr);
    chk({tag, ".busy"}, busy, 1'b0);
  endtask

  // Pulse reset, check reset outputs, then count busy cycles while hammering reads that must be ignored.
  task automatic reset_and_clear(input string tag);
    int cnt;
    reset = 1'b1; nen = 2'b11; nwrite = 1'b1; perr_clr = 1'b0; par_inj = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".rst_q"}, q, 4'h0);
    chk({tag, ".rst_q_valid"}, q_valid, 1'b0);
    chk({tag, ".rst_perr"}, perr, 1'b0);
    chk({tag, ".rst_busy"}, busy, 1'b1);
    reset = 1'b0;
    nen = 2'b00;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      addr = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      if (busy === 1'b1) begin
        chk({tag, ".clear_q"}, {q_valid, q}, 5'h00);
      end
    end
    chk({tag, ".busy_cycles"}, cnt, 16);
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 4'h0;
      m_bad[i] = 1'b0;
    end
    m_perr = 1'b0;
    nen = 2'b11;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0; addr = '0; d = '0; nen = 2'b11; nwrite = 1'b1; perr_clr = 1'b0; par_inj = 1'b0;
    m_perr = 1'b0;
    @(negedge clk);

    // 1: clear after reset, all words read zero with no parity error
    reset_and_clear("clr1");
    for (int i = 0; i < 16; i++) step(2'b00, 1'b1, 4'(i), 4'h0, 1'b0, 1'b0, "rd_cleared");

    // 2: write then read back, idle returns zero
    step(2'b00, 1'b0, 4'd5, 4'hA, 1'b0, 1'b0, "t2_wr");
    step(2'b00, 1'b1, 4'd5, 4'h0, 1'b0, 1'b0, "t2_rd");
    step(2'b11, 1'b1, 4'd5, 4'h0, 1'b0, 1'b0, "t2_idle");

    // 3: partial enable does not select the chip
    step(2'b00, 1'b0, 4'd3, 4'hF, 1'b0, 1'b0, "t3_wr");
    step(2'b01, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, "t3_rd_nen01");
    step(2'b10, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, "t3_rd_nen10");
    step(2'b00, 1'b1, 4'd3, 4'h0, 1'b0, 1'b0, "t3_rd_nen00");

    // 4: injected parity error is sticky until cleared
    step(2'b00, 1'b0, 4'd7, 4'h3, 1'b0, 1'b1, "t4_wr_inj");
    step(2'b00, 1'b1, 4'd7, 4'h0, 1'b0, 1'b0, "t4_rd_bad");
    step(2'b11, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, "t4_hold");
    step(2'b11, 1'b1, 4'd0, 4'h0, 1'b1, 1'b0, "t4_clr");

    // 5: error set beats clear; clear with a good read drops it
    step(2'b00, 1'b1, 4'd7, 4'h0, 1'b1, 1'b0, "t5_set_vs_clr");
    step(2'b00, 1'b1, 4'd5, 4'h0, 1'b1, 1'b0, "t5_good_clr");

    // 6: reset in the middle of clear restarts it and wipes earlier data
    step(2'b00, 1'b0, 4'd9, 4'h6, 1'b0, 1'b0, "t6_wr9");
    step(2'b00, 1'b0, 4'd2, 4'hC, 1'b0, 1'b0, "t6_wr2");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("t6_mid_busy", busy, 1'b1);
    reset_and_clear("clr6");
    for (int i = 0; i < 16; i++) step(2'b00, 1'b1, 4'(i), 4'h0, 1'b0, 1'b0, "t6_rd_cleared");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] en;
      en = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(en, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
